// File: rtl/rle_pkg.sv
// Shared types and constants for the RLE decoder: FSM states, pair layout and word geometry.
package rle_pkg;

    localparam int unsigned ADDR_W         = 16;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned MAX_RUN        = 255;
    localparam int unsigned RUN_W          = $clog2(MAX_RUN + 1);
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned PAIRS_PER_WORD = 2;
    localparam int unsigned PAIR_W         = DATA_W / PAIRS_PER_WORD;
    localparam int unsigned CNT_W          = $clog2(BYTES_PER_WORD + 1);
    localparam int unsigned SIZE_W         = 32;

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RWAIT,
        DEC,
        WRITE,
        FLUSH,
        DONE
    } state_t;

    // Within a pair the count is the low byte and the value the high byte.
    typedef struct packed {
        logic [BYTE_W-1:0] value;
        logic [RUN_W-1:0]  count;
    } pair_t;

    function automatic pair_t get_pair(input logic [DATA_W-1:0] w, input logic idx);
        return pair_t'(w[32'(idx) * PAIR_W +: PAIR_W]);
    endfunction

endpackage

// File: rtl/rle_byte_packer.sv
// Collects one byte per push into a little-endian 32-bit word; clear empties it.
module rle_byte_packer
    import rle_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [BYTE_W-1:0] data,
    input  logic              clear,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    output logic [DATA_W-1:0] word
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
            word  <= '0;
            full  <= 1'b0;
        end else if (push && !full) begin
            word[32'(count[1:0]) * BYTE_W +: BYTE_W] <= data;
            count <= count + CNT_W'(1);
            full  <= (count == CNT_W'(BYTES_PER_WORD - 1));
        end
    end

endmodule

// File: rtl/rle_decode.sv
// Expands (count,value) byte pairs from port A of the DPSRAM back into packed plaintext.
// Optional RLE_DEC_LIMIT_EN adds out_limit/overflow to cap the decoded length.
module rle_decode
    import rle_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       rle_addr,
    input  logic [31:0]       rle_size,
    input  logic [31:0]       message_addr,
`ifdef RLE_DEC_LIMIT_EN
    input  logic [31:0]       out_limit,
    output logic              overflow,
`endif
    output logic [SIZE_W-1:0] message_size,
    output logic              done,
    output logic              port_A_clk,
    output logic [ADDR_W-1:0] port_A_addr,
    output logic              port_A_we,
    output logic [DATA_W-1:0] port_A_data_in,
    input  logic [DATA_W-1:0] port_A_data_out
);

    state_t            state;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [30:0]       pairs_left;
    logic [DATA_W-1:0] in_word;
    logic              pair_idx;
    logic [RUN_W-1:0]  run_cnt;
    logic              word_end;

    logic              pk_push;
    logic              pk_clear;
    logic              pk_full;
    logic [CNT_W-1:0]  pk_count;
    logic [DATA_W-1:0] pk_word;

    pair_t             cur_pair;
    pair_t             next_pair;
    pair_t             rd_pair;
    logic [30:0]       pairs_next;
    logic              last_pair;
    logic              limit_hit;
    logic              limit_stop;
    logic              flush_now;
    logic              pair_done;
    logic              unused_bits;

    assign port_A_clk  = clk;
    assign unused_bits = ^{rle_addr[31:ADDR_W], message_addr[31:ADDR_W], rle_size[0]};

`ifdef RLE_DEC_LIMIT_EN
    assign limit_hit = (message_size >= out_limit);
`else
    assign limit_hit = 1'b0;
`endif

    // Pair bookkeeping and the DEC-state decisions shared by the FSM and the packer.
    always_comb begin
        cur_pair   = get_pair(in_word, pair_idx);
        next_pair  = get_pair(in_word, 1'b1);
        rd_pair    = get_pair(port_A_data_out, 1'b0);
        pairs_next = pairs_left - 31'd1;
        last_pair  = pair_idx || (pairs_next == '0);
        limit_stop = !word_end && (run_cnt != '0) && limit_hit;
        flush_now  = (word_end && (pairs_left == '0)) || limit_stop;
        pk_push    = (state == DEC) && !word_end && !limit_stop && (run_cnt != '0) && !pk_full;
        pair_done  = (state == DEC) && !word_end && !limit_stop &&
                     ((run_cnt == '0) || (pk_push && (run_cnt == RUN_W'(1))));
        pk_clear   = (state == WRITE) || (state == FLUSH) || ((state == IDLE) && start);
    end

    rle_byte_packer u_packer (
        .clk   (clk),
        .reset (reset),
        .push  (pk_push),
        .data  (cur_pair.value),
        .clear (pk_clear),
        .full  (pk_full),
        .count (pk_count),
        .word  (pk_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            rd_addr        <= '0;
            wr_addr        <= '0;
            pairs_left     <= '0;
            in_word        <= '0;
            pair_idx       <= 1'b0;
            run_cnt        <= '0;
            word_end       <= 1'b0;
            message_size   <= '0;
            done           <= 1'b0;
            port_A_addr    <= '0;
            port_A_we      <= 1'b0;
            port_A_data_in <= '0;
`ifdef RLE_DEC_LIMIT_EN
            overflow       <= 1'b0;
`endif
        end else begin
            port_A_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        rd_addr      <= rle_addr[ADDR_W-1:0] + ADDR_STEP;
                        wr_addr      <= message_addr[ADDR_W-1:0];
                        pairs_left   <= rle_size[31:1];
                        message_size <= '0;
                        done         <= 1'b0;
                        port_A_addr  <= rle_addr[ADDR_W-1:0];
`ifdef RLE_DEC_LIMIT_EN
                        overflow     <= 1'b0;
`endif
                        state        <= (rle_size[31:1] == '0) ? FLUSH : RADDR;
                    end
                end
                RADDR: state <= RWAIT;
                RWAIT: begin
                    in_word  <= port_A_data_out;
                    pair_idx <= 1'b0;
                    run_cnt  <= rd_pair.count;
                    word_end <= 1'b0;
                    state    <= DEC;
                end
                DEC: begin
                    if (flush_now) begin
                        // Outputs are set on entry so the write lands while in FLUSH.
                        port_A_we      <= (pk_count != '0);
                        port_A_addr    <= wr_addr;
                        port_A_data_in <= pk_word;
`ifdef RLE_DEC_LIMIT_EN
                        overflow       <= limit_stop;
`endif
                        state          <= FLUSH;
                    end else if (word_end) begin
                        port_A_addr <= rd_addr;
                        rd_addr     <= rd_addr + ADDR_STEP;
                        state       <= RADDR;
                    end else begin
                        if (pk_push) begin
                            message_size <= message_size + SIZE_W'(1);
                            run_cnt      <= run_cnt - RUN_W'(1);
                            if (pk_count == CNT_W'(BYTES_PER_WORD - 1)) begin
                                port_A_we      <= 1'b1;
                                port_A_addr    <= wr_addr;
                                port_A_data_in <= {cur_pair.value, pk_word[DATA_W-BYTE_W-1:0]};
                                state          <= WRITE;
                            end
                        end
                        if (pair_done) begin
                            pairs_left <= pairs_next;
                            if (last_pair) begin
                                word_end <= 1'b1;
                            end else begin
                                pair_idx <= 1'b1;
                                run_cnt  <= next_pair.count;
                            end
                        end
                    end
                end
                WRITE: begin
                    wr_addr <= wr_addr + ADDR_STEP;
                    state   <= DEC;
                end
                FLUSH: begin
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
